// File: rtl/life_pkg.sv
// Shared definitions for the life simulation slice: grid defaults, pattern
// encodings, per-pattern geometry and the pattern loader state encoding.
package life_pkg;

  localparam int GRID_W_DEF = 160;
  localparam int GRID_H_DEF = 120;

  localparam logic [1:0] PAT_GLIDER  = 2'd0;
  localparam logic [1:0] PAT_BLINKER = 2'd1;
  localparam logic [1:0] PAT_RPENT   = 2'd2;
  localparam logic [1:0] PAT_BLOCK   = 2'd3;

  localparam logic [2:0] N_GLIDER  = 3'd5;
  localparam logic [2:0] N_BLINKER = 3'd3;
  localparam logic [2:0] N_RPENT   = 3'd5;
  localparam logic [2:0] N_BLOCK   = 3'd4;

  localparam logic [1:0] W_GLIDER  = 2'd3;
  localparam logic [1:0] W_BLINKER = 2'd3;
  localparam logic [1:0] W_RPENT   = 2'd3;
  localparam logic [1:0] W_BLOCK   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } loader_state_t;

  function automatic logic [2:0] pattern_count(input logic [1:0] sel);
    case (sel)
      PAT_GLIDER:  return N_GLIDER;
      PAT_BLINKER: return N_BLINKER;
      PAT_RPENT:   return N_RPENT;
      default:     return N_BLOCK;
    endcase
  endfunction

  function automatic logic [1:0] pattern_width(input logic [1:0] sel);
    case (sel)
      PAT_GLIDER:  return W_GLIDER;
      PAT_BLINKER: return W_BLINKER;
      PAT_RPENT:   return W_RPENT;
      default:     return W_BLOCK;
    endcase
  endfunction

endpackage

// File: rtl/pattern_rom.sv
// Combinational seed-pattern table: (pattern_sel, index) -> cell offset and
// a flag marking the final cell of the pattern.
module pattern_rom
  import life_pkg::*;
(
  input  logic [1:0] pattern_sel,
  input  logic [2:0] index,
  output logic [1:0] dx,
  output logic [1:0] dy,
  output logic       last
);

  always_comb begin
    // NOTE: defaults first so every path assigns dx/dy and no latch is inferred.
    dx = 2'd0;
    dy = 2'd0;
    case (pattern_sel)
      PAT_GLIDER: case (index)
        3'd0:    begin dx = 2'd1; dy = 2'd0; end
        3'd1:    begin dx = 2'd2; dy = 2'd1; end
        3'd2:    begin dx = 2'd0; dy = 2'd2; end
        3'd3:    begin dx = 2'd1; dy = 2'd2; end
        default: begin dx = 2'd2; dy = 2'd2; end
      endcase
      PAT_BLINKER: begin
        dy = 2'd1;
        case (index)
          3'd0:    dx = 2'd0;
          3'd1:    dx = 2'd1;
          default: dx = 2'd2;
        endcase
      end
      PAT_RPENT: case (index)
        3'd0:    begin dx = 2'd1; dy = 2'd0; end
        3'd1:    begin dx = 2'd2; dy = 2'd0; end
        3'd2:    begin dx = 2'd0; dy = 2'd1; end
        3'd3:    begin dx = 2'd1; dy = 2'd1; end
        default: begin dx = 2'd1; dy = 2'd2; end
      endcase
      default: begin
        dx = {1'b0, index[0]};
        dy = {1'b0, index[1]};
      end
    endcase
  end

  assign last = (index == pattern_count(pattern_sel) - 3'd1);

endmodule

// File: rtl/pattern_loader.sv
// Streams one built-in seed pattern into the simulation core's load port,
// offset by a clamped origin and wrapped onto the grid.
// Optional: define PATTERN_LOADER_MIRROR_EN to add a horizontal mirror input.
module pattern_loader
  import life_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic [1:0] pattern_sel,
  input  logic [7:0] origin_x,
  input  logic [7:0] origin_y,
`ifdef PATTERN_LOADER_MIRROR_EN
  input  logic       mirror,
`endif
  input  logic       load_ready,
  output logic       load,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic       busy,
  output logic       done
);

  localparam logic [8:0] GW9 = 9'(GRID_W);
  localparam logic [8:0] GH9 = 9'(GRID_H);

  loader_state_t state_q, state_d;
  logic [1:0] sel_q;
  logic [7:0] ox_q, oy_q;
  logic [2:0] idx_q;
  logic       last_q;

  logic       idle, accept;
  logic [7:0] ox_clamp, oy_clamp, cx, cy, x_next, y_next;
  logic [1:0] rom_sel, dx, dy, dx_eff;
  logic [2:0] rom_idx;
  logic       rom_last;

  function automatic logic [7:0] wrap_add(input logic [7:0] o, input logic [1:0] d,
                                          input logic [8:0] dim);
    logic [8:0] s;
    s = {1'b0, o} + {7'b0, d};
    return 8'((s >= dim) ? s - dim : s);
  endfunction

  assign idle   = (state_q == ST_IDLE);
  assign accept = (state_q == ST_EMIT) && load_ready;

  assign ox_clamp = ({1'b0, origin_x} >= GW9) ? 8'(GW9 - 9'd1) : origin_x;
  assign oy_clamp = ({1'b0, origin_y} >= GH9) ? 8'(GH9 - 9'd1) : origin_y;

  // In IDLE the first beat is computed straight from the inputs so it is
  // ready on the cycle after start; later beats use the latched context.
  assign rom_sel = idle ? pattern_sel : sel_q;
  assign rom_idx = idle ? 3'd0 : idx_q + 3'd1;
  assign cx      = idle ? ox_clamp : ox_q;
  assign cy      = idle ? oy_clamp : oy_q;

  pattern_rom u_rom (
    .pattern_sel (rom_sel),
    .index       (rom_idx),
    .dx          (dx),
    .dy          (dy),
    .last        (rom_last)
  );

`ifdef PATTERN_LOADER_MIRROR_EN
  logic mirror_q, c_mirror;
  assign c_mirror = idle ? mirror : mirror_q;
  assign dx_eff   = c_mirror ? (pattern_width(rom_sel) - 2'd1 - dx) : dx;

  always_ff @(posedge clock) begin
    if (!reset_n)         mirror_q <= 1'b0;
    else if (idle && start) mirror_q <= mirror;
  end
`else
  assign dx_eff = dx;
`endif

  assign x_next = wrap_add(cx, dx_eff, GW9);
  assign y_next = wrap_add(cy, dy, GH9);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_EMIT;
      ST_EMIT: if (accept && last_q) state_d = ST_DONE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it is tested inside the clocked block only.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      sel_q   <= 2'd0;
      ox_q    <= 8'd0;
      oy_q    <= 8'd0;
      idx_q   <= 3'd0;
      last_q  <= 1'b0;
      x_out   <= 8'd0;
      y_out   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register update simultaneous.
      state_q <= state_d;
      if (idle && start) begin
        sel_q  <= pattern_sel;
        ox_q   <= ox_clamp;
        oy_q   <= oy_clamp;
        idx_q  <= 3'd0;
        last_q <= rom_last;
        x_out  <= x_next;
        y_out  <= y_next;
      end else if (accept && !last_q) begin
        idx_q  <= rom_idx;
        last_q <= rom_last;
        x_out  <= x_next;
        y_out  <= y_next;
      end
    end
  end

  assign load = (state_q == ST_EMIT);
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_pattern_loader.sv
// Directed self-checking bench for pattern_loader: latency, wrap, clamp,
// backpressure, ignored restarts and mid-pattern reset.
module tb_pattern_loader;
  import life_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n, start, load_ready, mirror;
  logic [1:0] pattern_sel;
  logic [7:0] origin_x, origin_y;
  logic       load, busy, done;
  logic [7:0] x_out, y_out;

  int n_cmp = 0;
  int n_bad = 0;

  // per-cycle samples and accepted beats of the last run
  logic       smp_load[16], smp_busy[16], smp_done[16];
  logic [7:0] smp_x[16], smp_y[16];
  int nb, done_n, done_c, busy_n, busy_first, busy_last;
  int bx[8], by[8], bc[8];
  int ex[8], ey[8], ec[8];

  always #5 clock = ~clock;

  pattern_loader dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .pattern_sel (pattern_sel),
    .origin_x    (origin_x),
    .origin_y    (origin_y),
`ifdef PATTERN_LOADER_MIRROR_EN
    .mirror      (mirror),
`endif
    .load_ready  (load_ready),
    .load        (load),
    .x_out       (x_out),
    .y_out       (y_out),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Cycle 0 is the cycle start is driven; inputs are set and outputs sampled
  // at each falling edge.
  task automatic run(input logic [1:0] sel, input logic [7:0] ox, input logic [7:0] oy,
                     input logic mir, input int lo_from, input int lo_to,
                     input int ra, input int rb, input int rst_c, input int ncyc);
    nb = 0; done_n = 0; done_c = -1; busy_n = 0; busy_first = -1; busy_last = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clock);
      pattern_sel = sel;
      origin_x    = ox;
      origin_y    = oy;
      mirror      = mir;
      start       = (c == 0) || (c == ra) || (c == rb);
      load_ready  = !(c >= lo_from && c <= lo_to);
      reset_n     = (c != rst_c);
      if (c < 16) begin
        smp_load[c] = load; smp_busy[c] = busy; smp_done[c] = done;
        smp_x[c] = x_out;   smp_y[c] = y_out;
      end
      if (load && load_ready && reset_n && nb < 8) begin
        bx[nb] = x_out; by[nb] = y_out; bc[nb] = c; nb++;
      end
      if (done) begin done_n++; done_c = c; end
      if (busy) begin
        busy_n++;
        if (busy_first < 0) busy_first = c;
        busy_last = c;
      end
    end
    @(negedge clock);
    start = 1'b0; load_ready = 1'b1; reset_n = 1'b1; mirror = 1'b0;
  endtask

  task automatic check_beats(input string tag, input int n);
    check({tag, ".beats"}, nb, n);
    for (int i = 0; i < n && i < nb; i++) begin
      check($sformatf("%s.x%0d", tag, i), bx[i], ex[i]);
      check($sformatf("%s.y%0d", tag, i), by[i], ey[i]);
      if (ec[i] >= 0) check($sformatf("%s.cyc%0d", tag, i), bc[i], ec[i]);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; load_ready = 1'b1; mirror = 1'b0;
    pattern_sel = PAT_GLIDER; origin_x = 8'd0; origin_y = 8'd0;
    repeat (3) @(negedge clock);
    check("rst.load", load, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.x", x_out, 0);
    check("rst.y", y_out, 0);
    reset_n = 1'b1;
    @(negedge clock);

    // glider, no backpressure
    run(PAT_GLIDER, 8'd10, 8'd20, 1'b0, -1, -1, -1, -1, -1, 9);
    ex = '{11, 12, 10, 11, 12, 0, 0, 0};
    ey = '{20, 21, 22, 22, 22, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5, 0, 0, 0};
    check_beats("glider", 5);
    check("glider.cyc0_load", smp_load[0], 0);
    check("glider.done_cyc", done_c, 6);
    check("glider.done_n", done_n, 1);
    check("glider.busy_first", busy_first, 1);
    check("glider.busy_last", busy_last, 6);
    check("glider.busy_n", busy_n, 6);

    // blinker at far corner: x and y wrap
    run(PAT_BLINKER, 8'd159, 8'd119, 1'b0, -1, -1, -1, -1, -1, 7);
    ex = '{159, 0, 1, 0, 0, 0, 0, 0};
    ey = '{0, 0, 0, 0, 0, 0, 0, 0};
    ec = '{1, 2, 3, 0, 0, 0, 0, 0};
    check_beats("blinker", 3);
    check("blinker.done_cyc", done_c, 4);

    // block with load_ready low on cycles 2..4
    run(PAT_BLOCK, 8'd0, 8'd0, 1'b0, 2, 4, -1, -1, -1, 11);
    ex = '{0, 1, 0, 1, 0, 0, 0, 0};
    ey = '{0, 0, 1, 1, 0, 0, 0, 0};
    ec = '{1, 5, 6, 7, 0, 0, 0, 0};
    check_beats("bp", 4);
    for (int c = 2; c <= 4; c++) begin
      check($sformatf("bp.hold_load%0d", c), smp_load[c], 1);
      check($sformatf("bp.hold_x%0d", c), smp_x[c], 1);
      check($sformatf("bp.hold_y%0d", c), smp_y[c], 0);
    end
    check("bp.done_cyc", done_c, 8);
    check("bp.done_n", done_n, 1);

    // start re-pulsed during EMIT and on the DONE cycle
    run(PAT_GLIDER, 8'd10, 8'd20, 1'b0, -1, -1, 2, 6, -1, 10);
    ex = '{11, 12, 10, 11, 12, 0, 0, 0};
    ey = '{20, 21, 22, 22, 22, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5, 0, 0, 0};
    check_beats("restart", 5);
    check("restart.done_n", done_n, 1);
    check("restart.busy7", smp_busy[7], 0);
    check("restart.load7", smp_load[7], 0);

    // reset during an R-pentomino
    run(PAT_RPENT, 8'd50, 8'd60, 1'b0, -1, -1, -1, -1, 3, 9);
    check("mid_rst.load4", smp_load[4], 0);
    check("mid_rst.busy4", smp_busy[4], 0);
    check("mid_rst.done4", smp_done[4], 0);
    check("mid_rst.x4", smp_x[4], 0);
    check("mid_rst.y4", smp_y[4], 0);
    check("mid_rst.done_n", done_n, 0);
    check("mid_rst.beats", nb, 2);

    run(PAT_RPENT, 8'd50, 8'd60, 1'b0, -1, -1, -1, -1, -1, 9);
    ex = '{51, 52, 50, 51, 51, 0, 0, 0};
    ey = '{60, 60, 61, 61, 62, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5, 0, 0, 0};
    check_beats("rpent", 5);
    check("rpent.done_cyc", done_c, 6);

    // reset asserted on the same cycle as start wins
    run(PAT_BLOCK, 8'd5, 8'd5, 1'b0, -1, -1, -1, -1, 0, 4);
    check("rst_start.busy1", smp_busy[1], 0);
    check("rst_start.beats", nb, 0);

    // out-of-range origin clamps to (159,119)
    run(PAT_BLOCK, 8'd200, 8'd130, 1'b0, -1, -1, -1, -1, -1, 8);
    ex = '{159, 0, 159, 0, 0, 0, 0, 0};
    ey = '{119, 119, 0, 0, 0, 0, 0, 0};
    ec = '{1, 2, 3, 4, 0, 0, 0, 0};
    check_beats("clamp", 4);
    check("clamp.done_cyc", done_c, 5);

`ifdef PATTERN_LOADER_MIRROR_EN
    run(PAT_GLIDER, 8'd10, 8'd20, 1'b1, -1, -1, -1, -1, -1, 9);
    ex = '{11, 10, 12, 11, 10, 0, 0, 0};
    ey = '{20, 21, 22, 22, 22, 0, 0, 0};
    ec = '{1, 2, 3, 4, 5, 0, 0, 0};
    check_beats("mirror", 5);
    check("mirror.done_cyc", done_c, 6);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
